// File: rtl/char_buffer_writer.sv
// Write side of the text-mode character buffer: clears the buffer after reset,
// writes printable bytes at the cursor, handles CR/LF/BS and scrolls by recycling the top row.
module char_buffer_writer #(
    parameter int ROWS      = 24,
    parameter int COLS      = 80,
    parameter int ROW_BITS  = 5,
    parameter int COL_BITS  = 7,
    parameter int ADDR_BITS = 11
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [7:0]           data_in,
    input  logic                 data_in_valid,
    output logic                 data_in_ready,
    output logic [COL_BITS-1:0]  cursor_x,
    output logic [ROW_BITS-1:0]  cursor_y,
    output logic [ADDR_BITS-1:0] first_char,
    output logic [ADDR_BITS-1:0] buf_addr,
    output logic [7:0]           buf_data,
    output logic                 buf_we
);

    localparam int PAST_LAST_ROW = ROWS * COLS;

    typedef enum logic [1:0] {INIT_CLEAR, IDLE, CLEAR_LINE} state_t;

    state_t               state_q, state_d;
    logic [ADDR_BITS-1:0] cnt_q, cnt_d;
    logic [COL_BITS-1:0]  cursor_x_q, cursor_x_d;
    logic [ROW_BITS-1:0]  cursor_y_q, cursor_y_d;
    logic [ADDR_BITS-1:0] first_char_q, first_char_d;
    logic [ADDR_BITS-1:0] line_start_q, line_start_d;
    logic [ADDR_BITS-1:0] buf_addr_q, buf_addr_d;
    logic [7:0]           buf_data_q, buf_data_d;
    logic                 buf_we_q, buf_we_d;
    logic                 ready_q, ready_d;

    // Advance a row-aligned address by one row, wrapping at the end of the buffer.
    function automatic logic [ADDR_BITS-1:0] next_row(input logic [ADDR_BITS-1:0] a);
        logic [ADDR_BITS:0] s;
        s = {1'b0, a} + (ADDR_BITS+1)'(COLS);
        if (s >= (ADDR_BITS+1)'(PAST_LAST_ROW)) begin
            return '0;
        end else begin
            return s[ADDR_BITS-1:0];
        end
    endfunction

    // Next-state and registered-output computation.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        cursor_x_d   = cursor_x_q;
        cursor_y_d   = cursor_y_q;
        first_char_d = first_char_q;
        line_start_d = line_start_q;
        buf_addr_d   = buf_addr_q;
        buf_data_d   = buf_data_q;
        buf_we_d     = 1'b0;
        ready_d      = ready_q;

        case (state_q)
            INIT_CLEAR: begin
                ready_d    = 1'b0;
                buf_we_d   = 1'b1;
                buf_addr_d = cnt_q;
                buf_data_d = 8'h20;
                if (cnt_q == ADDR_BITS'(PAST_LAST_ROW - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ADDR_BITS'(1);
                end
            end
            IDLE: begin
                ready_d = 1'b1;
                if (data_in_valid && ready_q) begin
                    if (data_in >= 8'h20 && data_in <= 8'h7E) begin
                        buf_we_d   = 1'b1;
                        buf_addr_d = line_start_q + {{(ADDR_BITS-COL_BITS){1'b0}}, cursor_x_q};
                        buf_data_d = data_in;
                        if (cursor_x_q != COL_BITS'(COLS - 1)) begin
                            cursor_x_d = cursor_x_q + COL_BITS'(1);
                        end else begin
                            cursor_x_d = cursor_x_q;
                        end
                    end else if (data_in == 8'h0D) begin
                        cursor_x_d = '0;
                    end else if (data_in == 8'h08) begin
                        if (cursor_x_q != '0) begin
                            cursor_x_d = cursor_x_q - COL_BITS'(1);
                        end else begin
                            cursor_x_d = cursor_x_q;
                        end
                    end else if (data_in == 8'h0A) begin
                        if (cursor_y_q != ROW_BITS'(ROWS - 1)) begin
                            cursor_y_d   = cursor_y_q + ROW_BITS'(1);
                            line_start_d = next_row(line_start_q);
                        end else begin
                            // First clear write issues with the acceptance; the rest follow in CLEAR_LINE.
                            state_d      = CLEAR_LINE;
                            ready_d      = 1'b0;
                            buf_we_d     = 1'b1;
                            buf_addr_d   = first_char_q;
                            buf_data_d   = 8'h20;
                            cnt_d        = ADDR_BITS'(1);
                            line_start_d = first_char_q;
                        end
                    end else begin
                        buf_we_d = 1'b0;
                    end
                end else begin
                    buf_we_d = 1'b0;
                end
            end
            CLEAR_LINE: begin
                ready_d = 1'b0;
                if (cnt_q == ADDR_BITS'(COLS)) begin
                    state_d      = IDLE;
                    ready_d      = 1'b1;
                    cnt_d        = '0;
                    first_char_d = next_row(first_char_q);
                end else begin
                    buf_we_d   = 1'b1;
                    buf_addr_d = first_char_q + cnt_q;
                    buf_data_d = 8'h20;
                    cnt_d      = cnt_q + ADDR_BITS'(1);
                end
            end
            default: begin
                state_d = INIT_CLEAR;
                cnt_d   = '0;
                ready_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= INIT_CLEAR;
            cnt_q        <= '0;
            cursor_x_q   <= '0;
            cursor_y_q   <= '0;
            first_char_q <= '0;
            line_start_q <= '0;
            buf_addr_q   <= '0;
            buf_data_q   <= 8'h20;
            buf_we_q     <= 1'b0;
            ready_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cursor_x_q   <= cursor_x_d;
            cursor_y_q   <= cursor_y_d;
            first_char_q <= first_char_d;
            line_start_q <= line_start_d;
            buf_addr_q   <= buf_addr_d;
            buf_data_q   <= buf_data_d;
            buf_we_q     <= buf_we_d;
            ready_q      <= ready_d;
        end
    end

    assign data_in_ready = ready_q;
    assign cursor_x      = cursor_x_q;
    assign cursor_y      = cursor_y_q;
    assign first_char    = first_char_q;
    assign buf_addr      = buf_addr_q;
    assign buf_data      = buf_data_q;
    assign buf_we        = buf_we_q;

endmodule

// File: tb/tb_char_buffer_writer.sv
// Bench for char_buffer_writer: directed sequences, a vector table and random bytes
// checked against a screen-level model of the character buffer.
module tb_char_buffer_writer;

    localparam int ROWS = 24;
    localparam int COLS = 80;
    localparam int SIZE = ROWS * COLS;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  data_in;
    logic        data_in_valid;
    logic        data_in_ready;
    logic [6:0]  cursor_x;
    logic [4:0]  cursor_y;
    logic [10:0] first_char;
    logic [10:0] buf_addr;
    logic [7:0]  buf_data;
    logic        buf_we;

    char_buffer_writer dut (
        .clk(clk), .reset(reset), .data_in(data_in), .data_in_valid(data_in_valid),
        .data_in_ready(data_in_ready), .cursor_x(cursor_x), .cursor_y(cursor_y),
        .first_char(first_char), .buf_addr(buf_addr), .buf_data(buf_data), .buf_we(buf_we)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int range_bad = 0;

    logic [7:0] dut_mem [2048];
    logic [7:0] m_mem   [SIZE];
    int m_x, m_y, m_fc;
    int wq_a[$];
    int wq_d[$];
    int wq_c[$];

    // Write monitor, sampled on the falling edge.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (buf_we) begin
            dut_mem[buf_addr] = buf_data;
            if (int'(buf_addr) >= SIZE) range_bad = range_bad + 1;
            wq_a.push_back(int'(buf_addr));
            wq_d.push_back(int'(buf_data));
            wq_c.push_back(cyc);
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_q();
        wq_a.delete();
        wq_d.delete();
        wq_c.delete();
    endtask

    task automatic model_reset();
        for (int i = 0; i < SIZE; i++) m_mem[i] = 8'h20;
        m_x = 0; m_y = 0; m_fc = 0;
    endtask

    task automatic model_apply(input logic [7:0] b);
        int a;
        if (b >= 8'h20 && b <= 8'h7E) begin
            a = (m_fc + m_y * COLS) % SIZE + m_x;
            m_mem[a] = b;
            if (m_x < COLS - 1) m_x++;
        end else if (b == 8'h0D) begin
            m_x = 0;
        end else if (b == 8'h08) begin
            if (m_x > 0) m_x--;
        end else if (b == 8'h0A) begin
            if (m_y < ROWS - 1) begin
                m_y++;
            end else begin
                for (int i = 0; i < COLS; i++) m_mem[m_fc + i] = 8'h20;
                m_fc = (m_fc + COLS) % SIZE;
            end
        end
    endtask

    task automatic wait_ready(input int bound);
        int n = 0;
        while (!data_in_ready && n < bound) begin
            tick();
            n++;
        end
        if (!data_in_ready) check("ready_timeout", 0, 1);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit hold);
        wait_ready(300);
        data_in = b;
        data_in_valid = 1'b1;
        tick();
        if (!hold) data_in_valid = 1'b0;
        model_apply(b);
    endtask

    task automatic check_cursor(input string name);
        check({name, "_x"}, int'(cursor_x), m_x);
        check({name, "_y"}, int'(cursor_y), m_y);
        check({name, "_fc"}, int'(first_char), m_fc);
    endtask

    task automatic reset_and_init(input int hold_cycles);
        int rel, bad;
        data_in_valid = 1'b0;
        reset = 1'b1;
        repeat (hold_cycles) tick();
        check("rst_ready", int'(data_in_ready), 0);
        check("rst_we", int'(buf_we), 0);
        check("rst_addr", int'(buf_addr), 0);
        check("rst_data", int'(buf_data), 32);
        check("rst_cursor", int'({cursor_y, cursor_x}), 0);
        check("rst_fc", int'(first_char), 0);
        reset = 1'b0;
        clear_q();
        rel = cyc;
        wait_ready(2500);
        model_reset();
        check("init_writes", wq_a.size(), SIZE);
        bad = 0;
        for (int i = 0; i < wq_a.size(); i++) begin
            if (wq_a[i] != i || wq_d[i] != 32 || wq_c[i] != rel + 1 + i) bad++;
        end
        check("init_seq_bad", bad, 0);
        if (wq_c.size() > 0) check("init_ready_cycle", cyc, wq_c[wq_c.size()-1] + 1);
        check_cursor("init");
    endtask

    typedef struct {
        logic [7:0] b;
        int         exp_x;
    } vec_t;

    initial begin
        vec_t vecs[5];
        int bad, n, old_fc;
        logic [7:0] rb;

        data_in = 8'h00;
        data_in_valid = 1'b0;
        reset = 1'b1;
        for (int i = 0; i < 2048; i++) dut_mem[i] = 8'h00;

        // Reset and full-buffer clear.
        reset_and_init(3);

        // Back-to-back printable bytes.
        clear_q();
        send_byte(8'h41, 1'b1);
        send_byte(8'h42, 1'b0);
        check("ab_count", wq_a.size(), 2);
        if (wq_a.size() == 2) begin
            check("a_addr", wq_a[0], 0);
            check("a_data", wq_d[0], 8'h41);
            check("b_addr", wq_a[1], 1);
            check("b_data", wq_d[1], 8'h42);
            check("ab_consecutive", wq_c[1] - wq_c[0], 1);
        end
        check("ab_x", int'(cursor_x), 2);

        // Saturation at the last column.
        send_byte(8'h0D, 1'b0);
        clear_q();
        for (int i = 0; i < 85; i++) send_byte(8'h30, (i != 84));
        check("sat_x", int'(cursor_x), COLS - 1);
        check("sat_count", wq_a.size(), 85);
        bad = 0;
        for (int i = 79; i < wq_a.size(); i++) if (wq_a[i] != 79) bad++;
        check("sat_last6_bad", bad, 0);

        // Vector table: BS/CR and a discarded control byte.
        vecs[0] = '{8'h08, 4};
        vecs[1] = '{8'h08, 3};
        vecs[2] = '{8'h0D, 0};
        vecs[3] = '{8'h08, 0};
        vecs[4] = '{8'h07, 0};
        send_byte(8'h0D, 1'b0);
        for (int i = 0; i < 5; i++) send_byte(8'h2E, 1'b0);
        check("vec_start_x", int'(cursor_x), 5);
        clear_q();
        for (int i = 0; i < 5; i++) begin
            send_byte(vecs[i].b, 1'b0);
            check($sformatf("vec%0d_x", i), int'(cursor_x), vecs[i].exp_x);
        end
        tick();
        check("vec_no_writes", wq_a.size(), 0);

        // Line feeds to the bottom row, then the first scroll.
        send_byte(8'h0D, 1'b0);
        for (int i = 0; i < 23; i++) send_byte(8'h0A, 1'b0);
        clear_q();
        send_byte(8'h5A, 1'b0);
        check("z_y", int'(cursor_y), 23);
        check("z_addr", (wq_a.size() == 1) ? wq_a[0] : -1, 1840);
        clear_q();
        send_byte(8'h0A, 1'b0);
        n = 0;
        while (!data_in_ready && n < 300) begin
            n++;
            tick();
        end
        check("scroll_ready_low", n, 80);
        check("scroll_writes", wq_a.size(), 80);
        bad = 0;
        for (int i = 0; i < wq_a.size(); i++) if (wq_a[i] != i || wq_d[i] != 32) bad++;
        check("scroll_range_bad", bad, 0);
        check_cursor("scroll1");
        send_byte(8'h0D, 1'b0);
        send_byte(8'h50, 1'b0);
        clear_q();
        send_byte(8'h51, 1'b0);
        check("q_addr", (wq_a.size() == 1) ? wq_a[0] : -1, 1);

        // Remaining scrolls until first_char wraps.
        bad = 0;
        for (int s = 0; s < 23; s++) begin
            old_fc = m_fc;
            clear_q();
            send_byte(8'h0A, 1'b0);
            wait_ready(300);
            if (wq_a.size() != 80) bad++;
            for (int i = 0; i < wq_a.size(); i++)
                if (wq_a[i] != old_fc + i || wq_a[i] >= SIZE) bad++;
            if (s == 21) check("fc_before_wrap", int'(first_char), 1840);
        end
        check("scrolls_bad", bad, 0);
        check("fc_wrapped", int'(first_char), 0);
        check_cursor("scroll24");
        bad = 0;
        for (int i = 0; i < SIZE; i++) if (dut_mem[i] !== m_mem[i]) bad++;
        check("mem_directed", bad, 0);

        // Reset in the middle of a scroll clear.
        send_byte(8'h0A, 1'b0);
        repeat (10) tick();
        check("midclear_ready", int'(data_in_ready), 0);
        reset_and_init(2);

        // Random bytes against the model.
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4: rb = 8'($urandom_range(32, 126));
                5:             rb = 8'h0D;
                6, 7:          rb = 8'h0A;
                8:             rb = 8'h08;
                default:       rb = 8'($urandom_range(127, 255));
            endcase
            send_byte(rb, 1'b0);
            wait_ready(300);
            check($sformatf("rnd%0d_x", i), int'(cursor_x), m_x);
            check($sformatf("rnd%0d_y", i), int'(cursor_y), m_y);
        end
        check("rnd_fc", int'(first_char), m_fc);
        bad = 0;
        for (int i = 0; i < SIZE; i++) if (dut_mem[i] !== m_mem[i]) bad++;
        check("mem_random", bad, 0);
        check("addr_range", range_bad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
